mult_seq_ctrl: RTL

Sequential shift-and-add controller for the 4x4 multiplier datapath. It drives an external AND array (4-bit A & 4-bit B -> 4-bit Y) once per multiplier bit and accumulates the partial products. It uses a start/busy/done handshake. This block sits between the operand source and the AND array, replacing the fully combinational array multiplier where area matters more than latency.

---
 rtl/mult_seq_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// Sequential shift-and-add 4x4 multiplier controller: drives an external AND
// array once per multiplier bit and accumulates partial products into P.
module mult_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   and_a,
  output logic [WIDTH-1:0]   and_b,
  input  logic [WIDTH-1:0]   and_y,
  output logic [2*WIDTH-1:0] P,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [2*WIDTH-1:0]   pp;
  logic [2*WIDTH-1:0]   acc_d;
  logic                 last_bit;

  always_comb begin
    and_a = '0;
    and_b = '0;
    if (state_q == S_RUN) begin
      and_a = a_q;
      and_b = {WIDTH{b_q[cnt_q]}};
    end
  end

  assign pp       = {{WIDTH{1'b0}}, and_y} << cnt_q;
  assign acc_d    = acc_q + pp;
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  // P is loaded with acc_d (not acc_q) so the final partial product is
  // included at the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            p_q     <= acc_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
